conv_pe_sequencer: RTL and testbench

CONV_PE_SEQUENCER -- requirements
Module: conv_pe_sequencer

---
 rtl/conv_pe_sequencer_if.sv | 32 +++
 rtl/conv_pe_sequencer.sv | 102 ++++++++++
 tb/tb_conv_pe_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pe_sequencer_if.sv
// Bundle of control, status and PE-array lanes between the sequencer and its
// environment. The slave side is the sequencer; the master side drives commands.
interface conv_pe_sequencer_if #(
    parameter int NUM_PE = 16,
    parameter int PIX_W  = 16,
    parameter int CPP_W  = 8
);
    logic              cal_start;
    logic              abort;
    logic [PIX_W-1:0]  num_pixels;
    logic [CPP_W-1:0]  cycles_per_pixel;
    logic [NUM_PE-1:0] pe_mask;
    logic              out_ready;
    logic [NUM_PE-1:0] valid_in;
    logic [NUM_PE-1:0] PE_en;
    logic [NUM_PE-1:0] PE_finish;
    logic              ofm_valid;
    logic              busy;
    logic              done;
    logic [PIX_W-1:0]  pixel_cnt;
    logic [PIX_W-1:0]  ofm_cnt;

    modport master (
        output cal_start, abort, num_pixels, cycles_per_pixel, pe_mask, out_ready, valid_in,
        input  PE_en, PE_finish, ofm_valid, busy, done, pixel_cnt, ofm_cnt
    );

    modport slave (
        input  cal_start, abort, num_pixels, cycles_per_pixel, pe_mask, out_ready, valid_in,
        output PE_en, PE_finish, ofm_valid, busy, done, pixel_cnt, ofm_cnt
    );
endinterface

// File: rtl/conv_pe_sequencer.sv
// Per-pixel sequencer for a convolution PE array: pulses start/finish on the
// masked lanes every cpp_eff cycles, honours downstream backpressure and abort.
module conv_pe_sequencer #(
    parameter int NUM_PE = 16,
    parameter int PIX_W  = 16,
    parameter int CPP_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    conv_pe_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_EN, S_RUN, S_FIN, S_HOLD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [NUM_PE-1:0] mask_q;
    logic [PIX_W-1:0]  num_pix_q;
    logic [PIX_W-1:0]  pixel_cnt_q;
    logic [PIX_W-1:0]  ofm_cnt_q;
    logic [CPP_W-1:0]  cpp_eff_q;
    logic [CPP_W-1:0]  run_cnt_q;
    logic [CPP_W-1:0]  cpp_eff_in;
    logic              en_q, fin_q, busy_q, done_q;
    logic              start_ok, last_pixel, ofm_valid;

    assign start_ok   = (state_q == S_IDLE) && bus.cal_start && !bus.abort;
    // A pixel needs at least EN, one RUN cycle and FIN.
    assign cpp_eff_in = (bus.cycles_per_pixel < CPP_W'(3)) ? CPP_W'(3) : bus.cycles_per_pixel;
    assign last_pixel = (PIX_W'(pixel_cnt_q + 1'b1) == num_pix_q);
    assign ofm_valid  = busy_q && ((bus.valid_in & mask_q) == mask_q) && (mask_q != '0);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_d = state_q;
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_DONE;
        end else begin
            case (state_q)
                S_IDLE: if (start_ok) state_d = (bus.num_pixels == '0) ? S_DONE : S_EN;
                S_EN:   state_d = S_RUN;
                S_RUN:  if (run_cnt_q == '0) state_d = S_FIN;
                S_FIN: begin
                    if (last_pixel)         state_d = S_DONE;
                    else if (bus.out_ready) state_d = S_EN;
                    else                    state_d = S_HOLD;
                end
                S_HOLD: if (bus.out_ready) state_d = S_EN;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every term reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            num_pix_q   <= '0;
            cpp_eff_q   <= '0;
            run_cnt_q   <= '0;
            pixel_cnt_q <= '0;
            ofm_cnt_q   <= '0;
            en_q        <= 1'b0;
            fin_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= (state_d == S_EN);
            fin_q   <= (state_d == S_FIN);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);

            // RUN occupies cpp_eff-2 cycles: load cpp_eff-3 on EN and count down to zero.
            if (state_q == S_EN) begin
                run_cnt_q <= cpp_eff_q - CPP_W'(3);
            end else if (state_q == S_RUN && run_cnt_q != '0) begin
                run_cnt_q <= run_cnt_q - 1'b1;
            end

            if (start_ok) begin
                mask_q      <= bus.pe_mask;
                num_pix_q   <= bus.num_pixels;
                cpp_eff_q   <= cpp_eff_in;
                pixel_cnt_q <= '0;
                ofm_cnt_q   <= '0;
            end else if (!bus.abort) begin
                if (state_q == S_FIN) pixel_cnt_q <= pixel_cnt_q + 1'b1;
                if (ofm_valid && ofm_cnt_q != '1) ofm_cnt_q <= ofm_cnt_q + 1'b1;
            end
        end
    end

    // Abort suppresses the lane pulses in the very cycle it is raised.
    assign bus.PE_en     = (en_q && !bus.abort) ? mask_q : '0;
    assign bus.PE_finish = (fin_q && !bus.abort) ? mask_q : '0;
    assign bus.ofm_valid = ofm_valid;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pixel_cnt = pixel_cnt_q;
    assign bus.ofm_cnt   = ofm_cnt_q;
endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Directed bench for conv_pe_sequencer: stimulus pushes expected lane/done/ofm
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_conv_pe_sequencer;
    localparam int NUM_PE = 16;
    localparam int PIX_W  = 16;
    localparam int CPP_W  = 8;

    typedef enum logic [1:0] {EV_EN, EV_FIN, EV_OFM, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e          kind;
        int                cyc;
        logic [NUM_PE-1:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_on = 1'b0;
    ev_t  exp_q[$];

    conv_pe_sequencer_if #(.NUM_PE(NUM_PE), .PIX_W(PIX_W), .CPP_W(CPP_W)) bus ();

    conv_pe_sequencer #(.NUM_PE(NUM_PE), .PIX_W(PIX_W), .CPP_W(CPP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input ev_kind_e k, input int c, input logic [NUM_PE-1:0] v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic sb_compare(input ev_kind_e kind, input logic [NUM_PE-1:0] val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL sb_%s: got value 0x%0h at cycle %0d, expected no event", kind.name(), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val !== val) begin
                n_errors++;
                $display("FAIL sb_event: got %s 0x%0h at cycle %0d, expected %s 0x%0h at cycle %0d",
                         kind.name(), val, cyc, e.kind.name(), e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.PE_en != '0)     sb_compare(EV_EN, bus.PE_en);
            if (bus.PE_finish != '0) sb_compare(EV_FIN, bus.PE_finish);
            if (bus.ofm_valid)       sb_compare(EV_OFM, NUM_PE'(1));
            if (bus.done)            sb_compare(EV_DONE, NUM_PE'(1));
        end
    end

    // Returns #1 after the posedge that makes cyc == t (immediately if already there).
    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives a one-cycle cal_start; s is the cycle in which EN (or DONE) appears.
    task automatic start(input int n, input int cpp, input logic [NUM_PE-1:0] mask, output int s);
        bus.num_pixels       = PIX_W'(n);
        bus.cycles_per_pixel = CPP_W'(cpp);
        bus.pe_mask          = mask;
        bus.cal_start        = 1'b1;
        @(posedge clk);
        #1;
        bus.cal_start = 1'b0;
        s = cyc;
    endtask

    task automatic run_plain(input string name, input int n, input int cpp, input logic [NUM_PE-1:0] mask);
        int s;
        int p;
        p = (cpp < 3) ? 3 : cpp;
        start(n, cpp, mask, s);
        for (int i = 0; i < n; i++) begin
            push(EV_EN, s + i * p, mask);
            push(EV_FIN, s + i * p + p - 1, mask);
        end
        push(EV_DONE, s + n * p, NUM_PE'(1));
        wait_cyc(s + n * p + 2);
        check({name, "_pixel_cnt"}, 32'(bus.pixel_cnt), 32'(n));
        check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({name, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        bus.cal_start        = 1'b0;
        bus.abort            = 1'b0;
        bus.num_pixels       = '0;
        bus.cycles_per_pixel = '0;
        bus.pe_mask          = '1;
        bus.out_ready        = 1'b1;
        bus.valid_in         = '1;

        // Reset state, with all lanes claiming valid to show ofm_valid stays low.
        repeat (3) @(posedge clk);
        #1;
        check("rst_PE_en", 32'(bus.PE_en), 32'd0);
        check("rst_PE_finish", 32'(bus.PE_finish), 32'd0);
        check("rst_ofm_valid", 32'(bus.ofm_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pixel_cnt", 32'(bus.pixel_cnt), 32'd0);
        check("rst_ofm_cnt", 32'(bus.ofm_cnt), 32'd0);
        bus.valid_in = '0;
        reset = 1'b0;
        mon_on = 1'b1;
        wait_cyc(cyc + 2);

        // Four 36-cycle pixels, then the minimum 3-cycle period from cpp=1.
        run_plain("run4_cpp36", 4, 36, 16'hFFFF);
        run_plain("run2_cpp1", 2, 1, 16'hFFFF);

        // Backpressure: out_ready low through FIN and nine HOLD cycles.
        bus.out_ready = 1'b0;
        start(2, 5, 16'hFFFF, s);
        push(EV_EN, s, 16'hFFFF);
        push(EV_FIN, s + 4, 16'hFFFF);
        push(EV_EN, s + 15, 16'hFFFF);
        push(EV_FIN, s + 19, 16'hFFFF);
        push(EV_DONE, s + 20, NUM_PE'(1));
        wait_cyc(s + 10);
        check("hold_busy", 32'(bus.busy), 32'd1);
        check("hold_pixel_cnt", 32'(bus.pixel_cnt), 32'd1);
        wait_cyc(s + 14);
        bus.out_ready = 1'b1;
        wait_cyc(s + 22);
        check("hold_pixel_cnt_end", 32'(bus.pixel_cnt), 32'd2);
        check("hold_sb_drain", 32'(exp_q.size()), 32'd0);

        // Partial mask: only the fully-valid cycle raises ofm_valid.
        start(1, 10, 16'h000F, s);
        push(EV_EN, s, 16'h000F);
        push(EV_OFM, s + 2, NUM_PE'(1));
        push(EV_FIN, s + 9, 16'h000F);
        push(EV_DONE, s + 10, NUM_PE'(1));
        wait_cyc(s + 2);
        bus.valid_in = 16'h000F;
        wait_cyc(s + 3);
        bus.valid_in = 16'h0007;
        wait_cyc(s + 4);
        bus.valid_in = '0;
        wait_cyc(s + 12);
        check("mask_ofm_cnt", 32'(bus.ofm_cnt), 32'd1);
        check("mask_pixel_cnt", 32'(bus.pixel_cnt), 32'd1);
        bus.valid_in = 16'h000F;
        wait_cyc(s + 15);
        bus.valid_in = '0;
        check("idle_ofm_cnt_hold", 32'(bus.ofm_cnt), 32'd1);
        check("mask_sb_drain", 32'(exp_q.size()), 32'd0);

        // Abort in RUN of pixel 3; a cal_start while busy must not disturb the run.
        start(5, 6, 16'hFFFF, s);
        push(EV_EN, s, 16'hFFFF);
        push(EV_FIN, s + 5, 16'hFFFF);
        push(EV_EN, s + 6, 16'hFFFF);
        push(EV_FIN, s + 11, 16'hFFFF);
        push(EV_EN, s + 12, 16'hFFFF);
        push(EV_DONE, s + 15, NUM_PE'(1));
        wait_cyc(s + 3);
        bus.num_pixels       = PIX_W'(1);
        bus.cycles_per_pixel = CPP_W'(3);
        bus.pe_mask          = 16'h0001;
        bus.cal_start        = 1'b1;
        wait_cyc(s + 4);
        bus.cal_start = 1'b0;
        check("abort_ofm_cnt_cleared", 32'(bus.ofm_cnt), 32'd0);
        wait_cyc(s + 14);
        bus.abort = 1'b1;
        wait_cyc(s + 15);
        bus.abort = 1'b0;
        wait_cyc(s + 18);
        check("abort_pixel_cnt", 32'(bus.pixel_cnt), 32'd2);
        check("abort_busy_after", 32'(bus.busy), 32'd0);

        // abort together with cal_start in IDLE: nothing starts, no done.
        bus.num_pixels = PIX_W'(3);
        bus.abort      = 1'b1;
        bus.cal_start  = 1'b1;
        wait_cyc(s + 19);
        bus.abort     = 1'b0;
        bus.cal_start = 1'b0;
        wait_cyc(s + 23);
        check("idle_abort_busy", 32'(bus.busy), 32'd0);
        check("idle_abort_pixel_cnt", 32'(bus.pixel_cnt), 32'd2);
        check("abort_sb_drain", 32'(exp_q.size()), 32'd0);

        // Zero-pixel run: busy and done together for a single cycle.
        start(0, 5, 16'hFFFF, s);
        push(EV_DONE, s, NUM_PE'(1));
        @(negedge clk);
        check("zero_busy", 32'(bus.busy), 32'd1);
        check("zero_pixel_cnt", 32'(bus.pixel_cnt), 32'd0);
        wait_cyc(s + 1);
        @(negedge clk);
        check("zero_busy_after", 32'(bus.busy), 32'd0);
        check("zero_sb_drain", 32'(exp_q.size()), 32'd0);
        wait_cyc(s + 3);

        // Reset mid-run after the first FIN: everything drops, no done pulse.
        start(3, 4, 16'hFFFF, s);
        push(EV_EN, s, 16'hFFFF);
        push(EV_FIN, s + 3, 16'hFFFF);
        push(EV_EN, s + 4, 16'hFFFF);
        wait_cyc(s + 5);
        check("midrst_pixel_cnt_before", 32'(bus.pixel_cnt), 32'd1);
        reset = 1'b1;
        wait_cyc(s + 6);
        check("midrst_PE_en", 32'(bus.PE_en), 32'd0);
        check("midrst_PE_finish", 32'(bus.PE_finish), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_pixel_cnt", 32'(bus.pixel_cnt), 32'd0);
        wait_cyc(s + 7);
        reset = 1'b0;
        wait_cyc(s + 16);
        check("midrst_busy_after", 32'(bus.busy), 32'd0);
        check("midrst_sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
